// File: rtl/lc4_regfile_pkg.sv
// Shared sizing constants and pending-counter helpers for the LC4 register file
// with scoreboard.
package lc4_regfile_pkg;

  localparam int unsigned N_DEFAULT    = 16;
  localparam int unsigned REGS_DEFAULT = 8;
  localparam int unsigned CNT_W        = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = 2'd3;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cnt_op_e;

  // A simultaneous reserve and retire on the same register cancel out.
  function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
    if (inc && !dec)      return CNT_INC;
    else if (dec && !inc) return CNT_DEC;
    else                  return CNT_HOLD;
  endfunction

endpackage

// File: rtl/lc4_sb_counter.sv
// Saturating 2-bit pending-write counter for one register, async active-low reset.
// Retiring a write at count 0 holds at 0 and raises o_underflow for that cycle.
module lc4_sb_counter
  import lc4_regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic gwe,
  input  logic i_inc,
  input  logic i_dec,
  output cnt_t o_count,
  output logic o_underflow
);

  cnt_t    r_count;
  cnt_op_e w_op;

  always_comb begin
    w_op = CNT_HOLD;
    if (gwe) w_op = cnt_op(i_inc, i_dec);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      case (w_op)
        CNT_INC: if (r_count != CNT_MAX) r_count <= r_count + 1'b1;
        CNT_DEC: if (r_count != '0)      r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_underflow = (w_op == CNT_DEC) && (r_count == '0);

endmodule

// File: rtl/lc4_regfile_sb.sv
// LC4 register file with per-register pending-write scoreboard.
// Define LC4_REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module lc4_regfile_sb
  import lc4_regfile_pkg::*;
#(
  parameter int unsigned n    = N_DEFAULT,
  parameter int unsigned REGS = REGS_DEFAULT,
  localparam int unsigned A   = $clog2(REGS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         gwe,
  input  logic [A-1:0] i_rs,
  input  logic [A-1:0] i_rt,
  output logic [n-1:0] o_rs_data,
  output logic [n-1:0] o_rt_data,
  input  logic [A-1:0] i_rd,
  input  logic [n-1:0] i_wdata,
  input  logic         i_rd_we,
  input  logic [A-1:0] i_iss_rd,
  input  logic         i_iss_v,
  output logic         o_rs_busy,
  output logic         o_rt_busy,
  output logic         o_iss_rdy,
  output logic         o_sb_err
);

  logic [n-1:0]    r_regs [REGS];
  logic            r_sb_err;
  cnt_t            w_cnt  [REGS];
  logic [REGS-1:0] w_underflow;
  logic            w_wb;
  logic            w_iss;

  // Qualifying with rst keeps the bypass path quiet while reset is held.
  assign w_wb  = i_rd_we & gwe & rst;
  assign w_iss = i_iss_v & gwe & o_iss_rdy & rst;

  assign o_iss_rdy = !((w_cnt[i_iss_rd] == CNT_MAX) && !(w_wb && (i_rd == i_iss_rd)));

  for (genvar g = 0; g < REGS; g++) begin : g_cnt
    lc4_sb_counter u_cnt (
      .clk         (clk),
      .rst         (rst),
      .gwe         (gwe),
      .i_inc       (w_iss && (i_iss_rd == A'(g))),
      .i_dec       (w_wb && (i_rd == A'(g))),
      .o_count     (w_cnt[g]),
      .o_underflow (w_underflow[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < REGS; i++) r_regs[i] <= '0;
    end else if (w_wb) begin
      r_regs[i_rd] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              r_sb_err <= 1'b0;
    else if (|w_underflow) r_sb_err <= 1'b1;
  end

  assign o_sb_err = r_sb_err;

  always_comb begin
    o_rs_busy = (w_cnt[i_rs] > 2'd1) || ((w_cnt[i_rs] == 2'd1) && !(w_wb && (i_rd == i_rs)));
    o_rt_busy = (w_cnt[i_rt] > 2'd1) || ((w_cnt[i_rt] == 2'd1) && !(w_wb && (i_rd == i_rt)));
  end

`ifdef LC4_REGFILE_BYPASS_EN
  assign o_rs_data = (w_wb && (i_rd == i_rs)) ? i_wdata : r_regs[i_rs];
  assign o_rt_data = (w_wb && (i_rd == i_rt)) ? i_wdata : r_regs[i_rt];
`else
  assign o_rs_data = r_regs[i_rs];
  assign o_rt_data = r_regs[i_rt];
`endif

endmodule

// File: tb/tb_lc4_regfile_sb.sv
// Self-checking bench for lc4_regfile_sb: directed scenarios plus randomized traffic
// checked against an array-based model of registers, pending counts and the error flag.
module tb_lc4_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gwe = 1'b0;
  logic [2:0]  i_rs = '0, i_rt = '0, i_rd = '0, i_iss_rd = '0;
  logic [15:0] i_wdata = '0;
  logic        i_rd_we = 1'b0, i_iss_v = 1'b0;
  logic [15:0] o_rs_data, o_rt_data;
  logic        o_rs_busy, o_rt_busy, o_iss_rdy, o_sb_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_regs [8];
  int          m_cnt  [8];
  logic        m_err;

  always #5 clk = ~clk;

  lc4_regfile_sb #(.n(16), .REGS(8)) dut (
    .clk(clk), .rst(rst), .gwe(gwe),
    .i_rs(i_rs), .i_rt(i_rt), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .i_rd(i_rd), .i_wdata(i_wdata), .i_rd_we(i_rd_we),
    .i_iss_rd(i_iss_rd), .i_iss_v(i_iss_v),
    .o_rs_busy(o_rs_busy), .o_rt_busy(o_rt_busy), .o_iss_rdy(o_iss_rdy), .o_sb_err(o_sb_err)
  );

  function automatic bit m_wb();
    return bit'(i_rd_we && gwe && rst);
  endfunction

  function automatic logic m_rdy();
    return !(m_cnt[i_iss_rd] == 3 && !(m_wb() && i_rd == i_iss_rd));
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] sel);
`ifdef LC4_REGFILE_BYPASS_EN
    if (m_wb() && i_rd == sel) return i_wdata;
`endif
    return m_regs[sel];
  endfunction

  function automatic logic m_busy(input logic [2:0] sel);
    return (m_cnt[sel] > 1) || (m_cnt[sel] == 1 && !(m_wb() && i_rd == sel));
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic void model_step();
    bit wb, iss;
    wb  = m_wb();
    iss = i_iss_v && gwe && rst && m_rdy();
    if (wb) m_regs[i_rd] = i_wdata;
    if (!(wb && iss && i_rd == i_iss_rd)) begin
      if (iss && m_cnt[i_iss_rd] < 3) m_cnt[i_iss_rd]++;
      if (wb) begin
        if (m_cnt[i_rd] == 0) m_err = 1'b1;
        else m_cnt[i_rd]--;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    gwe = 1'b1; i_rd_we = 1'b0; i_iss_v = 1'b0;
    i_rs = '0; i_rt = '0; i_rd = '0; i_iss_rd = '0; i_wdata = '0;
  endtask

  // Pulses reset between edges so no clock edge falls inside it.
  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    #2 rst = 1'b0;
    model_clear();
    #2 rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    i_rd = 3'd3; i_wdata = 16'h1234; i_rd_we = 1'b1;
    tick();
    @(negedge clk);
    i_rd_we = 1'b0; i_rs = 3'd3; i_rt = 3'd3;
    #1;
    n_checks++;
    if (o_rs_data !== 16'h1234) begin
      n_errors++; $display("FAIL reset_pre_data: got %h expected %h", o_rs_data, 16'h1234);
    end
    #1 rst = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (o_rs_data !== 16'h0000 || o_rt_data !== 16'h0000) begin
      n_errors++; $display("FAIL reset_data: got %h/%h expected 0000/0000", o_rs_data, o_rt_data);
    end
    n_checks++;
    if (o_iss_rdy !== 1'b1 || o_sb_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_flags: got rdy=%b err=%b expected rdy=1 err=0", o_iss_rdy, o_sb_err);
    end
    n_checks++;
    if (o_rs_busy !== 1'b0 || o_rt_busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_busy: got %b/%b expected 0/0", o_rs_busy, o_rt_busy);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_write_read();
    apply_reset();
    @(negedge clk);
    i_rd = 3'd5; i_wdata = 16'hBEEF; i_rd_we = 1'b1;
    tick();
    @(negedge clk);
    i_rd_we = 1'b0; i_rs = 3'd5;
    #1;
    n_checks++;
    if (o_rs_data !== 16'hBEEF) begin
      n_errors++; $display("FAIL write_read: got %h expected %h", o_rs_data, 16'hBEEF);
    end
    @(negedge clk);
    gwe = 1'b0; i_rd = 3'd5; i_wdata = 16'h1111; i_rd_we = 1'b1;
    tick();
    @(negedge clk);
    gwe = 1'b1; i_rd_we = 1'b0;
    #1;
    n_checks++;
    if (o_rs_data !== 16'hBEEF) begin
      n_errors++; $display("FAIL write_gwe0: got %h expected %h", o_rs_data, 16'hBEEF);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] exp;
    apply_reset();
    @(negedge clk);
    i_rd = 3'd2; i_wdata = 16'h00A5; i_rd_we = 1'b1; i_rt = 3'd2;
`ifdef LC4_REGFILE_BYPASS_EN
    exp = 16'h00A5;
`else
    exp = 16'h0000;
`endif
    #1;
    n_checks++;
    if (o_rt_data !== exp) begin
      n_errors++; $display("FAIL bypass_same_cycle: got %h expected %h", o_rt_data, exp);
    end
    tick();
    @(negedge clk);
    i_rd_we = 1'b0;
    #1;
    n_checks++;
    if (o_rt_data !== 16'h00A5) begin
      n_errors++; $display("FAIL bypass_next_cycle: got %h expected %h", o_rt_data, 16'h00A5);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_iss_v = 1'b1; i_iss_rd = 3'd1;
      #1;
      n_checks++;
      if (o_iss_rdy !== 1'b1) begin
        n_errors++; $display("FAIL sat_issue%0d: got rdy=%b expected 1", k, o_iss_rdy);
      end
      tick();
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (o_iss_rdy !== 1'b0) begin
      n_errors++; $display("FAIL sat_full: got rdy=%b expected 0", o_iss_rdy);
    end
    tick();
    @(negedge clk);
    i_rd = 3'd1; i_rd_we = 1'b1; i_wdata = 16'h0101;
    #1;
    n_checks++;
    if (o_iss_rdy !== 1'b1) begin
      n_errors++; $display("FAIL sat_wb_issue: got rdy=%b expected 1", o_iss_rdy);
    end
    tick();
    @(negedge clk);
    i_iss_v = 1'b0; i_rd_we = 1'b0; i_rs = 3'd1;
    #1;
    n_checks++;
    if (o_iss_rdy !== 1'b0 || o_rs_busy !== 1'b1 || o_sb_err !== 1'b0) begin
      n_errors++; $display("FAIL sat_still3: got rdy=%b busy=%b err=%b expected 0/1/0", o_iss_rdy, o_rs_busy, o_sb_err);
    end
  endtask

  task automatic test_busy_clear();
    apply_reset();
    @(negedge clk);
    i_iss_v = 1'b1; i_iss_rd = 3'd4;
    tick();
    @(negedge clk);
    i_iss_v = 1'b0; i_rs = 3'd4;
    #1;
    n_checks++;
    if (o_rs_busy !== 1'b1) begin
      n_errors++; $display("FAIL busy_pending: got %b expected 1", o_rs_busy);
    end
    @(negedge clk);
    i_rd = 3'd4; i_rd_we = 1'b1; i_wdata = 16'h4444;
    #1;
    n_checks++;
    if (o_rs_busy !== 1'b0) begin
      n_errors++; $display("FAIL busy_clear_wb: got %b expected 0", o_rs_busy);
    end
    tick();
    @(negedge clk);
    i_rd_we = 1'b0;
    #1;
    n_checks++;
    if (o_rs_busy !== 1'b0 || o_iss_rdy !== 1'b1 || o_sb_err !== 1'b0 || o_rs_data !== 16'h4444) begin
      n_errors++; $display("FAIL busy_after: got busy=%b rdy=%b err=%b data=%h expected 0/1/0/4444",
                           o_rs_busy, o_iss_rdy, o_sb_err, o_rs_data);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    @(negedge clk);
    i_rd = 3'd6; i_wdata = 16'h5A5A; i_rd_we = 1'b1; i_rs = 3'd6;
    #1;
    n_checks++;
    if (o_sb_err !== 1'b0) begin
      n_errors++; $display("FAIL uf_before: got %b expected 0", o_sb_err);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_rd_we = 1'b0;
      #1;
      n_checks++;
      if (o_sb_err !== 1'b1 || o_rs_data !== 16'h5A5A) begin
        n_errors++; $display("FAIL uf_sticky%0d: got err=%b data=%h expected 1/5a5a", k, o_sb_err, o_rs_data);
      end
      tick();
    end
    @(negedge clk);
    #2 rst = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (o_sb_err !== 1'b0) begin
      n_errors++; $display("FAIL uf_reset: got %b expected 0", o_sb_err);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 79) == 0) begin
        // Mid-run reset discards every outstanding reservation.
        #1 rst = 1'b0;
        model_clear();
        #1 rst = 1'b1;
      end
      gwe      = ($urandom_range(0, 9) != 0);
      i_rs     = 3'($urandom_range(0, 7));
      i_rt     = 3'($urandom_range(0, 7));
      i_rd     = 3'($urandom_range(0, 3));
      i_iss_rd = 3'($urandom_range(0, 3));
      i_wdata  = 16'($urandom);
      i_rd_we  = ($urandom_range(0, 2) == 0);
      i_iss_v  = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 3) == 0) i_rs = i_rd;
      #1;
      n_checks++;
      if (o_rs_data !== m_read(i_rs) || o_rt_data !== m_read(i_rt)) begin
        n_errors++; $display("FAIL rand_data c=%0d: got %h/%h expected %h/%h",
                             c, o_rs_data, o_rt_data, m_read(i_rs), m_read(i_rt));
      end
      n_checks++;
      if (o_rs_busy !== m_busy(i_rs) || o_rt_busy !== m_busy(i_rt)) begin
        n_errors++; $display("FAIL rand_busy c=%0d: got %b/%b expected %b/%b",
                             c, o_rs_busy, o_rt_busy, m_busy(i_rs), m_busy(i_rt));
      end
      n_checks++;
      if (o_iss_rdy !== m_rdy() || o_sb_err !== m_err) begin
        n_errors++; $display("FAIL rand_flags c=%0d: got rdy=%b err=%b expected rdy=%b err=%b",
                             c, o_iss_rdy, o_sb_err, m_rdy(), m_err);
      end
      tick();
    end
  endtask

  initial begin
    model_clear();
    idle_inputs();
    test_reset();
    test_write_read();
    test_bypass();
    test_saturation();
    test_busy_clear();
    test_underflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
